// File: rtl/keypad_scanner.sv
// 4x4 matrix keypad scanner: drives one row low at a time, debounces press and release, encodes the key as hex.
// Latency: press-to-o_key_valid is at most 4*SCAN_DIV + 2 + DEBOUNCE_CYCLES clocks, plus 1 for the registered outputs.
// Backpressure: none; o_key_valid is a single-clock pulse and o_key_code holds until the next accepted key.
module keypad_scanner #(
   parameter int SCAN_DIV        = 250,
   parameter int DEBOUNCE_CYCLES = 50000
) (
   input  logic       i_clk,
   input  logic       i_reset,
   input  logic [3:0] i_col_n,
   output logic [3:0] o_row_n,
   output logic [3:0] o_key_code,
   output logic       o_key_valid,
   output logic       o_key_down
);

   localparam int DW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
   localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
   localparam logic [DW-1:0] DWELL_LAST = DW'(SCAN_DIV - 1);
   localparam logic [CW-1:0] DEB_LAST   = CW'(DEBOUNCE_CYCLES - 1);

   typedef enum logic [1:0] {
      ST_SCAN     = 2'd0,
      ST_DEBOUNCE = 2'd1,
      ST_HELD     = 2'd2,
      ST_RELEASE  = 2'd3
   } state_t;

   state_t          r_state;
   state_t          w_state_nxt;

   logic [3:0]      r_col_meta;
   logic [3:0]      r_col_s;
   logic [1:0]      r_row;
   logic [1:0]      r_col;
   logic [DW-1:0]   r_dwell;
   logic [CW-1:0]   r_deb;
   logic [3:0]      r_row_n;
   logic [3:0]      r_key_code;
   logic            r_key_valid;
   logic            r_key_down;

   logic            w_any_low;
   logic [1:0]      w_low_idx;
   logic            w_sel_low;
   logic            w_dwell_last;
   logic            w_deb_last;
   logic [1:0]      w_row_nxt;

   logic            w_row_adv;
   logic            w_capture;
   logic            w_accept;
   logic            w_release;
   logic            w_dwell_inc;
   logic            w_deb_inc;

   // Hex code printed on the key at (row, col).
   function automatic logic [3:0] f_key_map(input logic [1:0] row, input logic [1:0] col);
      logic [3:0] code;
      case ({row, col})
         4'b00_00: code = 4'h1;
         4'b00_01: code = 4'h2;
         4'b00_10: code = 4'h3;
         4'b00_11: code = 4'hA;
         4'b01_00: code = 4'h4;
         4'b01_01: code = 4'h5;
         4'b01_10: code = 4'h6;
         4'b01_11: code = 4'hB;
         4'b10_00: code = 4'h7;
         4'b10_01: code = 4'h8;
         4'b10_10: code = 4'h9;
         4'b10_11: code = 4'hC;
         4'b11_00: code = 4'hE;
         4'b11_01: code = 4'h0;
         4'b11_10: code = 4'hF;
         default:  code = 4'hD;
      endcase
      return code;
   endfunction

   // Two-flop synchronizer; idle (all high) after reset so no phantom key is seen.
   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
         r_col_meta <= 4'hF;
         r_col_s    <= 4'hF;
      end else begin
         r_col_meta <= i_col_n;
         r_col_s    <= r_col_meta;
      end
   end

   // Lowest-index low column wins when several keys in the driven row are down.
   always_comb begin
      w_low_idx = 2'd0;
      if (!r_col_s[0]) begin
         w_low_idx = 2'd0;
      end else if (!r_col_s[1]) begin
         w_low_idx = 2'd1;
      end else if (!r_col_s[2]) begin
         w_low_idx = 2'd2;
      end else if (!r_col_s[3]) begin
         w_low_idx = 2'd3;
      end
   end

   assign w_any_low    = ~(&r_col_s);
   assign w_sel_low    = ~r_col_s[r_col];
   assign w_dwell_last = (r_dwell == DWELL_LAST);
   assign w_deb_last   = (r_deb == DEB_LAST);
   assign w_row_nxt    = r_row + 2'd1;

   // FSM state register.
   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
         r_state <= ST_SCAN;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // FSM next-state: a press or release must stay stable for the full debounce window.
   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         ST_SCAN: begin
            if (w_dwell_last && w_any_low) begin
               w_state_nxt = ST_DEBOUNCE;
            end
         end
         ST_DEBOUNCE: begin
            if (!w_sel_low) begin
               w_state_nxt = ST_SCAN;
            end else if (w_deb_last) begin
               w_state_nxt = ST_HELD;
            end
         end
         ST_HELD: begin
            if (!w_sel_low) begin
               w_state_nxt = ST_RELEASE;
            end
         end
         ST_RELEASE: begin
            if (w_sel_low) begin
               w_state_nxt = ST_HELD;
            end else if (w_deb_last) begin
               w_state_nxt = ST_SCAN;
            end
         end
         default: w_state_nxt = ST_SCAN;
      endcase
   end

   // FSM outputs: datapath strobes for counters, row pointer and key registers.
   always_comb begin
      w_row_adv   = 1'b0;
      w_capture   = 1'b0;
      w_accept    = 1'b0;
      w_release   = 1'b0;
      w_dwell_inc = 1'b0;
      w_deb_inc   = 1'b0;
      case (r_state)
         ST_SCAN: begin
            w_dwell_inc = ~w_dwell_last;
            w_capture   = w_dwell_last & w_any_low;
            w_row_adv   = w_dwell_last & ~w_any_low;
         end
         ST_DEBOUNCE: begin
            w_row_adv = ~w_sel_low;
            w_accept  = w_sel_low & w_deb_last;
            w_deb_inc = w_sel_low & ~w_deb_last;
         end
         ST_HELD: begin
            w_deb_inc = 1'b0;
         end
         ST_RELEASE: begin
            w_release = ~w_sel_low & w_deb_last;
            w_row_adv = ~w_sel_low & w_deb_last;
            w_deb_inc = ~w_sel_low & ~w_deb_last;
         end
         default: begin
            w_row_adv = 1'b0;
         end
      endcase
   end

   // Row dwell counter: runs only while scanning, cleared on the sampling cycle.
   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
         r_dwell <= '0;
      end else if (w_dwell_inc) begin
         r_dwell <= r_dwell + DW'(1);
      end else begin
         r_dwell <= '0;
      end
   end

   // Debounce counter: counts stable cycles and stops at the last one; any other condition clears it.
   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
         r_deb <= '0;
      end else if (w_deb_inc) begin
         r_deb <= r_deb + CW'(1);
      end else begin
         r_deb <= '0;
      end
   end

   // Row pointer and registered row drive; the 2-bit pointer wraps 3 -> 0 by design.
   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
         r_row   <= 2'd0;
         r_row_n <= 4'b1110;
      end else if (w_row_adv) begin
         r_row   <= w_row_nxt;
         r_row_n <= ~(4'b0001 << w_row_nxt);
      end
   end

   // Column of the candidate key, latched when the scan first sees it.
   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
         r_col <= 2'd0;
      end else if (w_capture) begin
         r_col <= w_low_idx;
      end
   end

   // Key outputs: code and pulse change together so a consumer sees the new code with the pulse.
   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
         r_key_code  <= 4'h0;
         r_key_valid <= 1'b0;
         r_key_down  <= 1'b0;
      end else begin
         r_key_valid <= w_accept;
         if (w_accept) begin
            r_key_code <= f_key_map(r_row, r_col);
            r_key_down <= 1'b1;
         end else if (w_release) begin
            r_key_down <= 1'b0;
         end
      end
   end

   assign o_row_n     = r_row_n;
   assign o_key_code  = r_key_code;
   assign o_key_valid = r_key_valid;
   assign o_key_down  = r_key_down;

endmodule

// File: tb/tb_keypad_scanner.sv
// Testbench for keypad_scanner with a switch-matrix keypad model (pressed key shorts its row to its column).
// Latency: expectations use SCAN_DIV=4, DEBOUNCE_CYCLES=8 timing.
// Backpressure: none; a monitor pops the expected-code queue on every o_key_valid pulse.
module tb_keypad_scanner;

   localparam int SCAN_DIV = 4;
   localparam int DEB      = 8;

   logic       clk   = 1'b0;
   logic       reset = 1'b1;
   logic [3:0] col_n;
   logic [3:0] row_n;
   logic [3:0] key_code;
   logic       key_valid;
   logic       key_down;
   logic [15:0] pressed = 16'h0000;

   int checks  = 0;
   int errors  = 0;
   int n_valid = 0;
   logic [3:0] exp_q[$];
   logic [3:0] sb_exp;

   keypad_scanner #(
      .SCAN_DIV       (SCAN_DIV),
      .DEBOUNCE_CYCLES(DEB)
   ) dut (
      .i_clk      (clk),
      .i_reset    (reset),
      .i_col_n    (col_n),
      .o_row_n    (row_n),
      .o_key_code (key_code),
      .o_key_valid(key_valid),
      .o_key_down (key_down)
   );

   always #5 clk = ~clk;

   // Keypad: pressed[r*4+c] pulls column c low while row r is driven low.
   always_comb begin
      col_n = 4'hF;
      for (int r = 0; r < 4; r++) begin
         for (int c = 0; c < 4; c++) begin
            if (pressed[r*4+c] && (row_n[r] == 1'b0)) begin
               col_n[c] = 1'b0;
            end
         end
      end
   end

   // Scoreboard monitor: every key_valid pulse must match the oldest expected code.
   always @(negedge clk) begin
      if (key_valid === 1'b1) begin
         n_valid++;
         checks++;
         if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL sb_unexpected: key_valid with key_code=%h, no key expected", key_code);
         end else begin
            sb_exp = exp_q.pop_front();
            if (key_code !== sb_exp) begin
               errors++;
               $display("FAIL sb_code: key_code=%h, required %h", key_code, sb_exp);
            end
         end
      end
   end

   task automatic cyc(input int n);
      repeat (n) begin
         @(negedge clk);
         #1;
      end
   endtask

   // Waits for the scanner to newly enter the row with drive pattern pat (bounded).
   task automatic wait_row(input logic [3:0] pat, input string name);
      int n = 0;
      while (row_n === pat && n < 40) begin
         cyc(1);
         n++;
      end
      while (row_n !== pat && n < 80) begin
         cyc(1);
         n++;
      end
      checks++;
      if (row_n !== pat) begin
         errors++;
         $display("FAIL %s: row_n=%b, required %b within 80 clocks", name, row_n, pat);
      end
   endtask

   task automatic test_reset();
      pressed = 16'h0;
      reset   = 1'b1;
      cyc(3);
      checks += 4;
      if (row_n !== 4'b1110) begin errors++; $display("FAIL rst_row_n: got %b, required 1110", row_n); end
      if (key_code !== 4'h0) begin errors++; $display("FAIL rst_key_code: got %h, required 0", key_code); end
      if (key_valid !== 1'b0) begin errors++; $display("FAIL rst_key_valid: got %b, required 0", key_valid); end
      if (key_down !== 1'b0) begin errors++; $display("FAIL rst_key_down: got %b, required 0", key_down); end
      reset = 1'b0;
      cyc(3);
      checks++;
      if (row_n !== 4'b1110) begin errors++; $display("FAIL scan_dwell: row_n=%b after 3 clks, required 1110", row_n); end
      cyc(1);
      checks++;
      if (row_n !== 4'b1101) begin errors++; $display("FAIL scan_r1: row_n=%b after 4 clks, required 1101", row_n); end
      cyc(8);
      checks++;
      if (row_n !== 4'b0111) begin errors++; $display("FAIL scan_r3: row_n=%b after 12 clks, required 0111", row_n); end
      cyc(4);
      checks++;
      if (row_n !== 4'b1110) begin errors++; $display("FAIL scan_wrap: row_n=%b after 16 clks, required 1110", row_n); end
   endtask

   task automatic test_press_5();
      int v0 = n_valid;
      exp_q.push_back(4'h5);
      pressed = 16'h0001 << 5;
      cyc(40);
      checks += 3;
      if (n_valid - v0 !== 1) begin errors++; $display("FAIL p5_pulses: got %0d, required 1", n_valid - v0); end
      if (key_code !== 4'h5) begin errors++; $display("FAIL p5_code: got %h, required 5", key_code); end
      if (key_down !== 1'b1) begin errors++; $display("FAIL p5_down: got %b, required 1", key_down); end
      pressed = 16'h0;
      cyc(10);
      checks++;
      if (key_down !== 1'b1) begin errors++; $display("FAIL p5_down_rel10: got %b, required 1", key_down); end
      cyc(2);
      checks++;
      if (key_down !== 1'b0) begin errors++; $display("FAIL p5_down_rel12: got %b, required 0", key_down); end
   endtask

   task automatic test_bounce_hash();
      int v0 = n_valid;
      exp_q.push_back(4'hF);
      for (int i = 0; i < 4; i++) begin
         pressed = 16'h0001 << 14;
         cyc(3);
         pressed = 16'h0;
         cyc(3);
      end
      pressed = 16'h0001 << 14;
      cyc(60);
      checks += 3;
      if (n_valid - v0 !== 1) begin errors++; $display("FAIL hash_pulses: got %0d, required 1", n_valid - v0); end
      if (key_code !== 4'hF) begin errors++; $display("FAIL hash_code: got %h, required F", key_code); end
      if (key_down !== 1'b1) begin errors++; $display("FAIL hash_down: got %b, required 1", key_down); end
      pressed = 16'h0;
      cyc(20);
   endtask

   task automatic test_glitch();
      int v0 = n_valid;
      wait_row(4'b1011, "glitch_sync_r2");
      pressed = 16'h0001 << 8;
      cyc(5);
      pressed = 16'h0;
      cyc(4);
      checks += 4;
      if (row_n !== 4'b0111) begin errors++; $display("FAIL glitch_next_row: row_n=%b, required 0111", row_n); end
      if (n_valid != v0) begin errors++; $display("FAIL glitch_pulses: got %0d, required 0", n_valid - v0); end
      if (key_code !== 4'hF) begin errors++; $display("FAIL glitch_code: got %h, required F", key_code); end
      if (key_down !== 1'b0) begin errors++; $display("FAIL glitch_down: got %b, required 0", key_down); end
   endtask

   task automatic test_hold_a();
      int v0 = n_valid;
      exp_q.push_back(4'hA);
      pressed = 16'h0001 << 3;
      cyc(100);
      for (int i = 0; i < 3; i++) begin
         pressed = 16'h0;
         cyc(2);
         pressed = 16'h0001 << 3;
         cyc(100);
         checks++;
         if (key_down !== 1'b1) begin errors++; $display("FAIL hold_down_%0d: got %b, required 1", i, key_down); end
      end
      checks += 2;
      if (n_valid - v0 !== 1) begin errors++; $display("FAIL hold_pulses: got %0d, required 1", n_valid - v0); end
      if (key_code !== 4'hA) begin errors++; $display("FAIL hold_code: got %h, required A", key_code); end
      pressed = 16'h0;
      cyc(20);
      checks++;
      if (key_down !== 1'b0) begin errors++; $display("FAIL hold_released: got %b, required 0", key_down); end
   endtask

   task automatic test_multi_key();
      int v0 = n_valid;
      exp_q.push_back(4'h1);
      pressed = (16'h0001 << 0) | (16'h0001 << 2);
      cyc(40);
      checks++;
      if (key_code !== 4'h1) begin errors++; $display("FAIL multi_same_row: got %h, required 1", key_code); end
      pressed = 16'h0;
      cyc(20);
      wait_row(4'b1101, "multi_sync_r1");
      exp_q.push_back(4'h4);
      pressed = (16'h0001 << 4) | (16'h0001 << 13);
      cyc(40);
      checks += 2;
      if (key_code !== 4'h4) begin errors++; $display("FAIL multi_diff_row: got %h, required 4", key_code); end
      if (n_valid - v0 !== 2) begin errors++; $display("FAIL multi_pulses: got %0d, required 2", n_valid - v0); end
      pressed = 16'h0;
      cyc(20);
   endtask

   task automatic test_reset_held();
      int n  = 0;
      int v0;
      exp_q.push_back(4'h5);
      pressed = 16'h0001 << 5;
      while (key_down !== 1'b1 && n < 60) begin
         cyc(1);
         n++;
      end
      checks++;
      if (key_down !== 1'b1) begin errors++; $display("FAIL rh_reach_held: key_down=%b, required 1 within 60 clocks", key_down); end
      cyc(2);
      #2;
      reset = 1'b1;
      #1;
      checks += 4;
      if (row_n !== 4'b1110) begin errors++; $display("FAIL rh_row_n: got %b, required 1110", row_n); end
      if (key_code !== 4'h0) begin errors++; $display("FAIL rh_key_code: got %h, required 0", key_code); end
      if (key_down !== 1'b0) begin errors++; $display("FAIL rh_key_down: got %b, required 0", key_down); end
      if (key_valid !== 1'b0) begin errors++; $display("FAIL rh_key_valid: got %b, required 0", key_valid); end
      pressed = 16'h0;
      cyc(3);
      reset = 1'b0;
      v0 = n_valid;
      cyc(20);
      checks += 2;
      if (n_valid != v0) begin errors++; $display("FAIL rh_exit_pulse: got %0d pulses, required 0", n_valid - v0); end
      if (key_down !== 1'b0) begin errors++; $display("FAIL rh_exit_down: got %b, required 0", key_down); end
      exp_q.push_back(4'h9);
      pressed = 16'h0001 << 10;
      cyc(40);
      checks += 3;
      if (n_valid - v0 !== 1) begin errors++; $display("FAIL rh_repress_pulses: got %0d, required 1", n_valid - v0); end
      if (key_code !== 4'h9) begin errors++; $display("FAIL rh_repress_code: got %h, required 9", key_code); end
      if (key_down !== 1'b1) begin errors++; $display("FAIL rh_repress_down: got %b, required 1", key_down); end
      pressed = 16'h0;
      cyc(20);
      checks++;
      if (key_down !== 1'b0) begin errors++; $display("FAIL rh_repress_release: got %b, required 0", key_down); end
   endtask

   initial begin
      test_reset();
      test_press_5();
      test_bounce_hash();
      test_glitch();
      test_hold_a();
      test_multi_key();
      test_reset_held();
      checks++;
      if (exp_q.size() != 0) begin
         errors++;
         $display("FAIL sb_leftover: %0d expected keys never reported, required 0", exp_q.size());
      end
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
